// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad emulator: row strobe codes,
// special keycodes, FSM state encoding and the keymap record.
package keypad_pkg;

  localparam logic [3:0] ROW0     = 4'b1110;
  localparam logic [3:0] ROW1     = 4'b1101;
  localparam logic [3:0] ROW2     = 4'b1011;
  localparam logic [3:0] ROW3     = 4'b0111;
  localparam logic [3:0] ROW_NONE = 4'b1111;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] COLS_IDLE = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // col_code is already in active-low form, ready to drive onto cols
  typedef struct packed {
    logic [3:0] row_code;
    logic [2:0] col_code;
    logic       valid;
  } keymap_t;

endpackage

// File: rtl/keypad_emulator_if.sv
// Keycode handshake plus the row-scan lines between scanner and emulator.
// key_in transfers on a rising edge where key_valid and key_ready are both 1;
// key_valid while key_ready is 0 is ignored and nothing is queued.
interface keypad_emulator_if;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] rows;
  logic [2:0] cols;
  logic       pressed;
  logic       done;
  logic       err;

  modport master (
    output key_in, key_valid, rows,
    input  key_ready, cols, pressed, done, err
  );

  modport slave (
    input  key_in, key_valid, rows,
    output key_ready, cols, pressed, done, err
  );
endinterface

// File: rtl/keypad_keymap.sv
// Combinational keycode -> {row strobe, active-low column, valid} lookup
// for the 3x4 keypad layout.
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [3:0] i_key,
  output keymap_t    o_map
);

  always_comb begin
    o_map = '{row_code: ROW_NONE, col_code: COLS_IDLE, valid: 1'b0};
    case (i_key)
      4'd1:     o_map = '{row_code: ROW0, col_code: 3'b110, valid: 1'b1};
      4'd2:     o_map = '{row_code: ROW0, col_code: 3'b101, valid: 1'b1};
      4'd3:     o_map = '{row_code: ROW0, col_code: 3'b011, valid: 1'b1};
      4'd4:     o_map = '{row_code: ROW1, col_code: 3'b110, valid: 1'b1};
      4'd5:     o_map = '{row_code: ROW1, col_code: 3'b101, valid: 1'b1};
      4'd6:     o_map = '{row_code: ROW1, col_code: 3'b011, valid: 1'b1};
      4'd7:     o_map = '{row_code: ROW2, col_code: 3'b110, valid: 1'b1};
      4'd8:     o_map = '{row_code: ROW2, col_code: 3'b101, valid: 1'b1};
      4'd9:     o_map = '{row_code: ROW2, col_code: 3'b011, valid: 1'b1};
      KEY_STAR: o_map = '{row_code: ROW3, col_code: 3'b110, valid: 1'b1};
      4'd0:     o_map = '{row_code: ROW3, col_code: 3'b101, valid: 1'b1};
      KEY_HASH: o_map = '{row_code: ROW3, col_code: 3'b011, valid: 1'b1};
      default:  o_map = '{row_code: ROW_NONE, col_code: COLS_IDLE, valid: 1'b0};
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of the keypad row scan: presses an accepted key for
// HOLD_SCANS row-0 entries, then forces release for GAP_SCANS entries.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  keypad_emulator_if.slave    bus,
  output logic [1:0]          o_state
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_PRESS   = PRESS;
  localparam logic [1:0] S_RELEASE = RELEASE;
  localparam logic [7:0] HOLD_N    = 8'(HOLD_SCANS);
  localparam logic [7:0] GAP_N     = 8'(GAP_SCANS);

  logic [1:0] r_state;
  logic [7:0] r_scan_cnt;
  logic [3:0] r_rows_q;
  logic [3:0] r_key_q;
  logic       r_done;
  logic       r_err;

  logic       w_accept;
  logic       w_scan_evt;
  logic [7:0] w_cnt_inc;
  keymap_t    w_map;

  keypad_keymap u_keymap (
    .i_key (r_key_q),
    .o_map (w_map)
  );

  assign bus.key_ready = (r_state == S_IDLE) && !reset;
  assign w_accept      = bus.key_valid && bus.key_ready;
  // Only the entry into row 0 counts as a scan, never the dwell on it
  assign w_scan_evt    = (bus.rows == ROW0) && (r_rows_q != ROW0);
  assign w_cnt_inc     = r_scan_cnt + 8'd1;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_scan_cnt <= 8'd0;
      r_rows_q   <= ROW_NONE;
      r_key_q    <= 4'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rows_q <= bus.rows;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      if (w_accept) r_key_q <= bus.key_in;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.key_in <= KEY_HASH) begin
              r_state    <= S_PRESS;
              r_scan_cnt <= 8'd0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PRESS: begin
          if (w_scan_evt) begin
            if (w_cnt_inc == HOLD_N) begin
              r_state    <= S_RELEASE;
              r_scan_cnt <= 8'd0;
            end else begin
              r_scan_cnt <= w_cnt_inc;
            end
          end
        end
        S_RELEASE: begin
          if (w_scan_evt) begin
            if (w_cnt_inc == GAP_N) begin
              r_state    <= S_IDLE;
              r_scan_cnt <= 8'd0;
              r_done     <= 1'b1;
            end else begin
              r_scan_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_scan_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Zero latency from rows: the scanner samples cols within its strobe
  always_comb begin
    bus.cols = COLS_IDLE;
    if ((r_state == S_PRESS) && w_map.valid && (bus.rows == w_map.row_code))
      bus.cols = w_map.col_code;
  end

  assign bus.pressed = (r_state == S_PRESS);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a vector table of key/row/cols cases
// plus hand-written multi-cycle sequences for hold, gap, reset and errors.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_fail   = 0;

  keypad_emulator_if bus_if ();

  keypad_emulator #(
    .HOLD_SCANS (4),
    .GAP_SCANS  (2)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus_if),
    .o_state  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [3:0] rows;
    logic [2:0] exp_cols;
  } vec_t;

  vec_t       vecs[17];
  logic [3:0] row_codes[4];
  logic [3:0] kc_tab[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus_if.key_valid = 1'b0;
    bus_if.key_in    = 4'd0;
    bus_if.rows      = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_key(input logic [3:0] k, input bit hold_valid);
    bus_if.key_in    = k;
    bus_if.key_valid = 1'b1;
    #1;
    check("ready_before_accept", {7'd0, bus_if.key_ready}, 8'd1);
    tick();
    if (!hold_valid) bus_if.key_valid = 1'b0;
    #1;
    check("pressed_after_accept", {7'd0, bus_if.pressed}, 8'd1);
  endtask

  // Rows cycle 1110,1101,1011,0111 for 8 cycles each. Row-0 entries at the
  // start of rounds 0..3 bring the count to 4 (release on round 3 entry);
  // entries at rounds 4 and 5 complete the gap, so done shows on round 5
  // row 0 cycle 1, where the task returns.
  task automatic run_schedule(input int exp_j, input logic [2:0] pat,
                              input int swap_round, input logic [3:0] swap_key);
    logic exp_p;
    logic exp_d;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) begin
        for (int c = 0; c < 8; c++) begin
          if (r == swap_round && j == 0 && c == 0) bus_if.key_in = swap_key;
          bus_if.rows = row_codes[j];
          #1;
          exp_p = (r < 3) || (r == 3 && j == 0 && c == 0);
          exp_d = (r == 5 && j == 0 && c == 1);
          check("sched_pressed", {7'd0, bus_if.pressed}, {7'd0, exp_p});
          check("sched_cols", {5'd0, bus_if.cols},
                {5'd0, (exp_p && j == exp_j) ? pat : 3'b111});
          check("sched_done", {7'd0, bus_if.done}, {7'd0, exp_d});
          if (exp_d) begin
            check("sched_ready_on_done", {7'd0, bus_if.key_ready}, 8'd1);
            return;
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] code;
    bit         found;
    int         ci;

    row_codes = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    kc_tab    = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
    vecs = '{
      '{4'd10, 4'b0111, 3'b110}, '{4'd10, 4'b1110, 3'b111},
      '{4'd10, 4'b1101, 3'b111}, '{4'd10, 4'b1011, 3'b111},
      '{4'd0,  4'b0111, 3'b101}, '{4'd0,  4'b1110, 3'b111},
      '{4'd0,  4'b1101, 3'b111}, '{4'd0,  4'b1011, 3'b111},
      '{4'd11, 4'b0111, 3'b011}, '{4'd11, 4'b1110, 3'b111},
      '{4'd11, 4'b1011, 3'b111},
      '{4'd1,  4'b1110, 3'b110}, '{4'd1,  4'b1111, 3'b111},
      '{4'd1,  4'b0000, 3'b111}, '{4'd1,  4'b0111, 3'b111},
      '{4'd5,  4'b1101, 3'b101}, '{4'd5,  4'b1011, 3'b111}
    };

    // Reset values
    reset            = 1'b1;
    bus_if.key_valid = 1'b0;
    bus_if.key_in    = 4'd0;
    bus_if.rows      = 4'b1111;
    tick();
    tick();
    tick();
    check("rst_ready", {7'd0, bus_if.key_ready}, 8'd0);
    check("rst_cols", {5'd0, bus_if.cols}, 8'h07);
    check("rst_pressed", {7'd0, bus_if.pressed}, 8'd0);
    check("rst_done", {7'd0, bus_if.done}, 8'd0);
    check("rst_err", {7'd0, bus_if.err}, 8'd0);
    check("rst_state", {6'd0, state_dbg}, 8'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {7'd0, bus_if.key_ready}, 8'd1);
    tick();

    // Table: key pressed, rows driven, expected cols
    foreach (vecs[i]) begin
      do_reset();
      send_key(vecs[i].key, 1'b0);
      bus_if.rows = vecs[i].rows;
      #1;
      check($sformatf("vec%0d_cols", i), {5'd0, bus_if.cols}, {5'd0, vecs[i].exp_cols});
    end

    // Key 5 through a full hold and gap
    do_reset();
    send_key(4'd5, 1'b0);
    run_schedule(1, 3'b101, -1, 4'd0);
    tick();
    check("k5_done_cleared", {7'd0, bus_if.done}, 8'd0);
    check("k5_idle_ready", {7'd0, bus_if.key_ready}, 8'd1);
    check("k5_idle_pressed", {7'd0, bus_if.pressed}, 8'd0);

    // Illegal keycode 13
    do_reset();
    bus_if.rows      = 4'b0111;
    bus_if.key_in    = 4'd13;
    bus_if.key_valid = 1'b1;
    #1;
    check("err_ready_before", {7'd0, bus_if.key_ready}, 8'd1);
    tick();
    bus_if.key_valid = 1'b0;
    #1;
    check("err_pulse", {7'd0, bus_if.err}, 8'd1);
    check("err_ready", {7'd0, bus_if.key_ready}, 8'd1);
    check("err_pressed", {7'd0, bus_if.pressed}, 8'd0);
    check("err_cols", {5'd0, bus_if.cols}, 8'h07);
    check("err_no_done", {7'd0, bus_if.done}, 8'd0);
    tick();
    check("err_pulse_end", {7'd0, bus_if.err}, 8'd0);
    check("err_no_done2", {7'd0, bus_if.done}, 8'd0);

    // key_valid held through press of 7, key_in switches to 2 mid-press
    do_reset();
    send_key(4'd7, 1'b1);
    run_schedule(2, 3'b110, 1, 4'd2);
    tick();
    bus_if.key_valid = 1'b0;
    #1;
    check("k2_pressed_after_done", {7'd0, bus_if.pressed}, 8'd1);
    check("k2_cols_row0", {5'd0, bus_if.cols}, 8'h05);
    check("k2_ready_low", {7'd0, bus_if.key_ready}, 8'd0);

    // Reset during press of key 9 on row 1011
    do_reset();
    send_key(4'd9, 1'b0);
    bus_if.rows = 4'b1011;
    #1;
    check("k9_cols", {5'd0, bus_if.cols}, 8'h03);
    tick();
    reset = 1'b1;
    tick();
    check("k9_rst_cols", {5'd0, bus_if.cols}, 8'h07);
    check("k9_rst_pressed", {7'd0, bus_if.pressed}, 8'd0);
    check("k9_rst_done", {7'd0, bus_if.done}, 8'd0);
    check("k9_rst_ready_low", {7'd0, bus_if.key_ready}, 8'd0);
    reset = 1'b0;
    #1;
    check("k9_ready_after", {7'd0, bus_if.key_ready}, 8'd1);
    tick();
    check("k9_no_done", {7'd0, bus_if.done}, 8'd0);
    check("k9_idle_pressed", {7'd0, bus_if.pressed}, 8'd0);

    // Bench-side row scanner decodes the emulator's response to key 1
    do_reset();
    send_key(4'd1, 1'b0);
    found = 1'b0;
    code  = 4'hF;
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 2; c++) begin
        bus_if.rows = row_codes[j];
        #1;
        ci = (bus_if.cols == 3'b110) ? 0 : (bus_if.cols == 3'b101) ? 1 :
             (bus_if.cols == 3'b011) ? 2 : -1;
        if (ci >= 0 && !found) begin
          found = 1'b1;
          code  = kc_tab[j * 3 + ci];
        end
        tick();
      end
    end
    check("scan_found", {7'd0, found}, 8'd1);
    check("scan_keycode", {4'd0, code}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
